// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus bundle: instruction memory req/ack side,
// redirect input and the valid/ready instruction output.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata,
    input  redirect,
    input  redirect_pc,
    output instr_valid,
    output instr,
    output instr_pc,
    input  instr_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata,
    output redirect,
    output redirect_pc,
    input  instr_valid,
    input  instr,
    input  instr_pc,
    output instr_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, imem req/ack, prefetch FIFO, redirect flush.
// Optional FETCH_PERF_CNT_EN adds pop and wait-cycle counters.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic CLK,
  input  logic Reset,
  instr_fetch_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_instr_count,
  output logic [31:0] perf_wait_cycles
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEP = FIFO_DEPTH[AW:0];

  typedef enum logic {S_FETCH, S_DISCARD} state_t;

  state_t      r_state;
  logic        r_req;
  logic [31:0] r_addr;
  logic [31:0] r_tgt;
  logic [AW:0] r_cnt;
  logic [AW-1:0] r_rp;
  logic [AW-1:0] r_wp;
  logic [31:0] r_word [FIFO_DEPTH];
  logic [31:0] r_pc   [FIFO_DEPTH];

  state_t      w_state_n;
  logic        w_req_n;
  logic [31:0] w_addr_n;
  logic [31:0] w_tgt_n;
  logic [AW:0] w_cnt_n;
  logic        w_xfer;
  logic        w_valid;
  logic        w_flush;
  logic        w_push;
  logic        w_pop;
  logic [31:0] w_rtgt;

  // next-state: redirect flush beats push/pop; DISCARD eats one stale ack
  always_comb begin
    w_state_n = r_state;
    w_addr_n  = r_addr;
    w_tgt_n   = r_tgt;
    w_flush   = 1'b0;
    w_push    = 1'b0;
    w_xfer    = r_req & bus.imem_ack;
    w_valid   = r_cnt != '0;
    w_rtgt    = {bus.redirect_pc[31:2], 2'b00};
    w_pop     = w_valid & bus.instr_ready & ~bus.redirect;
    unique case (r_state)
      S_FETCH: begin
        if (bus.redirect) begin
          w_flush = 1'b1;
          if (r_req & ~bus.imem_ack) begin
            w_tgt_n   = w_rtgt;
            w_state_n = S_DISCARD;
          end else begin
            w_addr_n = w_rtgt;
          end
        end else if (w_xfer) begin
          w_push   = 1'b1;
          w_addr_n = r_addr + 32'd4;
        end
      end
      S_DISCARD: begin
        if (bus.redirect) begin
          w_flush = 1'b1;
          w_tgt_n = w_rtgt;
        end
        if (w_xfer) begin
          w_addr_n  = bus.redirect ? w_rtgt : r_tgt;
          w_state_n = S_FETCH;
        end
      end
      default: w_state_n = S_FETCH;
    endcase
    if (w_flush)
      w_cnt_n = '0;
    else
      w_cnt_n = r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    w_req_n = w_cnt_n < DEP;
  end

  // control state, request, address and FIFO pointers
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      r_state <= S_FETCH;
      r_req   <= 1'b0;
      r_addr  <= RESET_PC;
      r_tgt   <= RESET_PC;
      r_cnt   <= '0;
      r_rp    <= '0;
      r_wp    <= '0;
    end else begin
      r_state <= w_state_n;
      r_req   <= w_req_n;
      r_addr  <= w_addr_n;
      r_tgt   <= w_tgt_n;
      r_cnt   <= w_cnt_n;
      if (w_flush) begin
        r_rp <= '0;
        r_wp <= '0;
      end else begin
        if (w_push) r_wp <= r_wp + 1'b1;
        if (w_pop)  r_rp <= r_rp + 1'b1;
      end
    end
  end

  // FIFO storage write, word paired with its fetch PC
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_word[r_wp] <= bus.imem_rdata;
      r_pc[r_wp]   <= r_addr;
    end
  end

  assign bus.imem_req    = r_req;
  assign bus.imem_addr   = r_addr;
  assign bus.instr_valid = w_valid;
  assign bus.instr       = w_valid ? r_word[r_rp] : 32'h0000_0013;
  assign bus.instr_pc    = w_valid ? r_pc[r_rp] : 32'h0;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_pop;
  logic [31:0] r_perf_wait;

  // pop and memory-stall counters, free-running wrap
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      r_perf_pop  <= '0;
      r_perf_wait <= '0;
    end else begin
      if (w_pop)
        r_perf_pop <= r_perf_pop + 32'd1;
      if (r_req & ~bus.imem_ack)
        r_perf_wait <= r_perf_wait + 32'd1;
    end
  end

  assign perf_instr_count = r_perf_pop;
  assign perf_wait_cycles = r_perf_wait;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed cases
// followed by random ack/ready/redirect/reset traffic.
module tb_instr_fetch_unit;
  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_unit_if bus();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] pic;
  logic [31:0] pwc;
`endif

  instr_fetch_unit #(
    .RESET_PC(RPC),
    .FIFO_DEPTH(D)
  ) dut (
    .CLK(clk),
    .Reset(rst_n),
    .bus(bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_instr_count(pic),
    .perf_wait_cycles(pwc)
`endif
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F ^ {a[15:0], a[31:16]};
  endfunction

  assign bus.imem_rdata = bus.imem_ack ? memf(bus.imem_addr) : 32'hDEAD_BEEF;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: expected stream of {pc, word}
  logic [63:0] q[$];
  logic [31:0] exp_fetch = RPC;
  bit stale = 0;
  bit rst_flag = 0;
  bit armed = 0;
  logic [31:0] e_pops = 0;
  logic [31:0] e_wait = 0;

  // monitor at negedge: compare, then advance model for next edge
  always @(negedge clk) begin
    bit er;
    bit xf;
    logic [31:0] tg;
    er = !rst_flag && (q.size() < D);
    if (armed) begin
      chk("req", {31'b0, bus.imem_req}, {31'b0, er});
      if (!stale) chk("addr", bus.imem_addr, exp_fetch);
      chk("valid", {31'b0, bus.instr_valid}, {31'b0, q.size() != 0});
      if (q.size() != 0) begin
        chk("instr_pc", bus.instr_pc, q[0][63:32]);
        chk("instr", bus.instr, q[0][31:0]);
      end else begin
        chk("nop", bus.instr, 32'h0000_0013);
        chk("pc_zero", bus.instr_pc, 32'h0);
      end
`ifdef FETCH_PERF_CNT_EN
      chk("perf_instr", pic, e_pops);
      chk("perf_wait", pwc, e_wait);
`endif
    end
    if (!rst_n) begin
      q.delete();
      exp_fetch = RPC;
      stale = 0;
      rst_flag = 1;
      armed = 1;
      e_pops = 0;
      e_wait = 0;
    end else if (armed) begin
      rst_flag = 0;
      xf = er && bus.imem_ack;
      tg = {bus.redirect_pc[31:2], 2'b00};
      if (er && !bus.imem_ack) e_wait = e_wait + 1;
      if (bus.redirect) begin
        q.delete();
        exp_fetch = tg;
        stale = er && !bus.imem_ack;
      end else begin
        if (q.size() != 0 && bus.instr_ready) begin
          void'(q.pop_front());
          e_pops = e_pops + 1;
        end
        if (xf) begin
          if (stale) begin
            stale = 0;
          end else begin
            q.push_back({exp_fetch, memf(exp_fetch)});
            exp_fetch = exp_fetch + 32'd4;
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic redir(input logic [31:0] pc);
    bus.redirect = 1'b1;
    bus.redirect_pc = pc;
    tick(1);
    bus.redirect = 1'b0;
  endtask

  initial begin
    bus.imem_ack = 1'b1;
    bus.instr_ready = 1'b1;
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'h0;
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(10);
    // fill with ready low, then single pop
    bus.instr_ready = 1'b0;
    redir(32'h0);
    tick(8);
    bus.instr_ready = 1'b1;
    tick(1);
    bus.instr_ready = 1'b0;
    tick(3);
    bus.instr_ready = 1'b1;
    tick(4);
    // redirect on an ack cycle
    redir(32'h0);
    tick(2);
    redir(32'h100);
    tick(5);
    // redirect during a memory stall
    bus.imem_ack = 1'b0;
    redir(32'h200);
    tick(2);
    bus.imem_ack = 1'b1;
    tick(5);
    // misaligned target and PC wrap
    redir(32'h103);
    tick(4);
    redir(32'hFFFF_FFF4);
    tick(5);
    // reset with outstanding request and two buffered entries
    bus.instr_ready = 1'b0;
    redir(32'h40);
    tick(2);
    bus.imem_ack = 1'b0;
    tick(1);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    bus.imem_ack = 1'b1;
    bus.instr_ready = 1'b1;
    tick(3);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      bus.imem_ack = ($urandom_range(0, 3) != 0);
      bus.instr_ready = ($urandom_range(0, 2) != 0);
      bus.redirect = ($urandom_range(0, 15) == 0);
      bus.redirect_pc = $urandom();
      rst_n = ($urandom_range(0, 499) != 0);
      tick(1);
    end
    bus.redirect = 1'b0;
    rst_n = 1'b1;
    tick(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the single-cycle datapath. Owns the fetch PC and issues word reads to instruction memory over a req/ack handshake.
- Buffers returned words with their PCs in a small prefetch FIFO and presents them to the datapath with valid/ready.
- A redirect (branch/jump taken) flushes the FIFO and restarts fetch at the target.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.
- FIFO_DEPTH, 4, prefetch entries; power of 2, >=2.

Ports:
- CLK  in  1  clock, rising edge
- Reset  in  1  reset, synchronous, active-low
- imem_req  out  1  read request; held until imem_ack
- imem_addr  out  32  word address; stable while imem_req=1; bits[1:0] always 00
- imem_ack  in  1  request accepted and imem_rdata valid this cycle
- imem_rdata  in  32  instruction word
- redirect  in  1  flush and restart fetch
- redirect_pc  in  32  restart target
- instr_valid  out  1  FIFO head valid
- instr  out  32  head instruction; 32'h0000_0013 (NOP) when instr_valid=0
- instr_pc  out  32  head PC; 0 when instr_valid=0
- instr_ready  in  1  datapath consumes head

Behaviour:
- Reset:
  - Reset=0 at a rising edge sets imem_req=0, imem_addr=RESET_PC, fetch_pc=RESET_PC, FIFO count=0, instr_valid=0, state=FETCH.
  - Any outstanding request is abandoned.
- Handshake:
  - imem_req, imem_addr and FIFO are registered. A transfer occurs in any cycle with imem_req=1 and imem_ack=1.
  - At most one request is outstanding.
  - Combinational instruction memory ties imem_ack=1, giving 1 word/cycle.
- Pop: when instr_valid=1 and instr_ready=1, the head is removed at the edge.
- Issue rule: at each edge, imem_req_next=1 iff Reset=1 and count_next < FIFO_DEPTH, where count_next includes push and pop this cycle. A push never occurs into a full FIFO.
- States:
  - FETCH:
    - On ack without redirect: push {imem_rdata, imem_addr}; imem_addr <= imem_addr+4.
    - On redirect, with or without ack: flush FIFO (count=0); imem_addr <= {redirect_pc[31:2],2'b00}; any acked data is dropped.
    - On redirect while imem_req=1 and imem_ack=0: latch target, go to DISCARD.
  - DISCARD:
    - imem_req stays 1 and imem_addr keeps the old address until ack.
    - Returned data is dropped; the latched target loads into imem_addr; go to FETCH with imem_req=1 next cycle.
    - A further redirect in DISCARD overwrites the latched target and re-flushes. If it arrives on the ack cycle, the new target wins.
- Flush precedence: redirect beats push and pop in the same cycle. instr_valid=0 in the cycle after redirect.
- PC arithmetic: 32-bit, wraps 0xFFFF_FFFC -> 0x0000_0000 silently.
- instr_valid=1 iff count!=0; head data comes from FIFO storage, not combinationally from imem_rdata.
- Latency with ack tied 1 and empty FIFO: word fetched in cycle N is visible on instr in cycle N+1.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_instr_count (32) and perf_wait_cycles (32).
  - perf_instr_count: +1 per pop.
  - perf_wait_cycles: +1 per cycle with imem_req=1 and imem_ack=0.
  - Both reset to 0 on Reset=0 and wrap at 2^32.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset release, RESET_PC=0, ack=1, ready=1 -> imem_addr 0,4,8,... on consecutive cycles; instr_valid=1 from the second cycle after release with instr_pc 0,4,8,...; instr equals memory words.
- ready=0, ack=1, FIFO_DEPTH=4 -> exactly 4 transfers then imem_req=0; instr_pc stays 0. ready=1 for one cycle -> one pop, imem_req=1 the next cycle, addr 0x10.
- Redirect with redirect_pc=0x100 in the same cycle as an ack at 0x8 -> word at 0x8 dropped; instr_valid=0 next cycle; next imem_addr=0x100; first delivered instr_pc=0x100.
- ack=0 for 3 cycles, redirect (0x200) in the first of them -> imem_addr holds old value until ack; that data is dropped; then imem_addr=0x200, and no stale instruction ever appears with instr_valid=1.
- redirect_pc=0x103 -> imem_addr=0x100, instr_pc=0x100. PC 0xFFFF_FFFC with ack -> next addr 0x0.
- Reset=0 while imem_req=1, ack=0, FIFO holding 2 entries -> next cycle imem_req=0, instr_valid=0, instr=0x13, imem_addr=RESET_PC. With FETCH_PERF_CNT_EN, both counters read 0.
